// File: rtl/div_control.sv
// Sequencing controller for the shift-subtract divider: drives the Remainder register controls.
// Optional divide-by-zero short-cut enabled by defining DIV_ZERO_CHECK_EN.
module div_control #(
  parameter int ITER_N = 32
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] Divisor_in,
  output logic        W_ctrl,
  output logic        SLL_ctrl,
  output logic        SRL_ctrl,
  output logic        Ready,
  output logic        Busy,
  output logic [5:0]  Count,
  output logic        Div_zero
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT0 = 3'd1,
    ITER   = 3'd2,
    FIX    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'(ITER_N - 1);

  state_t state;
  logic   zero_req;

`ifdef DIV_ZERO_CHECK_EN
  assign zero_req = (Divisor_in == 32'd0);
`else
  logic divisor_unused;
  assign divisor_unused = ^Divisor_in;
  assign zero_req       = 1'b0;
`endif

  // Outputs are written together with the state they belong to, so they are
  // stable a full half-cycle before the Remainder register samples at negedge.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      W_ctrl   <= 1'b1;
      SLL_ctrl <= 1'b0;
      SRL_ctrl <= 1'b0;
      Ready    <= 1'b0;
      Busy     <= 1'b0;
      Count    <= 6'd0;
      Div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            W_ctrl <= 1'b0;
            Count  <= 6'd0;
            if (zero_req) begin
              state    <= DONE;
              Ready    <= 1'b1;
              Div_zero <= 1'b1;
            end else begin
              state    <= SHIFT0;
              SLL_ctrl <= 1'b1;
              Busy     <= 1'b1;
            end
          end
        end
        SHIFT0: begin
          state <= ITER;
        end
        ITER: begin
          Count <= Count + 6'd1;
          if (Count == LAST_ITER) begin
            state    <= FIX;
            SLL_ctrl <= 1'b0;
            SRL_ctrl <= 1'b1;
          end
        end
        FIX: begin
          state    <= DONE;
          SRL_ctrl <= 1'b0;
          Busy     <= 1'b0;
          Ready    <= 1'b1;
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state    <= IDLE;
          W_ctrl   <= 1'b1;
          SLL_ctrl <= 1'b0;
          SRL_ctrl <= 1'b0;
          Ready    <= 1'b0;
          Busy     <= 1'b0;
          Count    <= 6'd0;
          Div_zero <= 1'b0;
        end
      endcase
    end
  end

endmodule
